// File: rtl/wbus_if.sv
// W-bus bundle between the byte-wide sources, the wide (PC) channel and the arbiter.
// The arbiter side uses the slave modport; the source/load side uses master.
interface wbus_if #(
  parameter int DW    = 8,
  parameter int N_SRC = 9,
  parameter int CW    = 8,
  parameter int SW    = $clog2(N_SRC + 1)
);
  // Handshake: there is no ready/back-pressure. A source is granted in the cycle its
  // src_en is sampled; bus_valid qualifies bus/bus_src/bus_hi for exactly one cycle and
  // every load must take the value in that cycle. wide_req is a one-cycle request that
  // is accepted only while the wide channel is idle and otherwise dropped.
  logic [N_SRC*DW-1:0] src_data;
  logic [N_SRC-1:0]    src_en;
  logic                wide_req;
  logic [2*DW-1:0]     wide_data;
  logic                clr_err;

  logic [DW-1:0]       bus;
  logic                bus_valid;
  logic [SW-1:0]       bus_src;
  logic                bus_hi;
  logic                wide_busy;
  logic                wide_done;
  logic                contention;
  logic [CW-1:0]       cont_cnt;

  modport slave (
    input  src_data, src_en, wide_req, wide_data, clr_err,
    output bus, bus_valid, bus_src, bus_hi, wide_busy, wide_done, contention, cont_cnt
  );

  modport master (
    output src_data, src_en, wide_req, wide_data, clr_err,
    input  bus, bus_valid, bus_src, bus_hi, wide_busy, wide_done, contention, cont_cnt
  );
endinterface

// File: rtl/wbus_arbiter.sv
// Registered W-bus arbiter: highest-index byte source wins, a two-beat FSM carries the
// double-width PC value, and overlapping drivers are flagged and counted.
module wbus_arbiter #(
  parameter int DW    = 8,
  parameter int N_SRC = 9,
  parameter int CW    = 8,
  parameter int SW    = $clog2(N_SRC + 1)
) (
  input  logic       CLK,
  input  logic       CLR,
  wbus_if.slave      wb,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;

  localparam logic [SW-1:0]    SRC_WIDE = SW'(N_SRC);
  localparam logic [N_SRC-1:0] EN_ONE   = N_SRC'(1);
  localparam logic [CW-1:0]    CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic [1:0]    state;
  logic [DW-1:0] hold_hi;
  logic [DW-1:0] bus_q;
  logic          bus_valid_q;
  logic [SW-1:0] bus_src_q;
  logic          bus_hi_q;
  logic          contention_q;
  logic [CW-1:0] cont_cnt_q;

  logic [SW-1:0] win_idx;
  logic [DW-1:0] win_data;
  logic          any_en;
  logic          multi_en;
  logic          in_wide;
  logic          cont_event;

  // Priority select: later (higher) indices overwrite earlier ones.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (wb.src_en[i]) begin
        win_idx  = SW'(i);
        win_data = wb.src_data[i*DW +: DW];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits are set.
  assign any_en   = |wb.src_en;
  assign multi_en = |(wb.src_en & (wb.src_en - EN_ONE));
  assign in_wide  = (state == ST_LO) || (state == ST_HI);

  always_comb begin
    cont_event = 1'b0;
    if (in_wide) begin
      cont_event = any_en;
    end else begin
      cont_event = multi_en || (wb.wide_req && any_en);
    end
  end

  // Bus and wide FSM. The low beat is registered straight from wide_data, so only the
  // upper half has to be held for the second beat.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state       <= ST_IDLE;
      hold_hi     <= '0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q   <= '0;
      bus_hi_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wb.wide_req) begin
            state       <= ST_LO;
            hold_hi     <= wb.wide_data[2*DW-1:DW];
            bus_q       <= wb.wide_data[DW-1:0];
            bus_valid_q <= 1'b1;
            bus_src_q   <= SRC_WIDE;
            bus_hi_q    <= 1'b0;
          end else if (any_en) begin
            bus_q       <= win_data;
            bus_valid_q <= 1'b1;
            bus_src_q   <= win_idx;
            bus_hi_q    <= 1'b0;
          end else begin
            bus_valid_q <= 1'b0;
          end
        end
        ST_LO: begin
          state       <= ST_HI;
          bus_q       <= hold_hi;
          bus_valid_q <= 1'b1;
          bus_src_q   <= SRC_WIDE;
          bus_hi_q    <= 1'b1;
        end
        ST_HI: begin
          state       <= ST_IDLE;
          bus_valid_q <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          bus_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Contention tracking; an event in the same cycle as clr_err restarts the count at one.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      contention_q <= 1'b0;
      cont_cnt_q   <= '0;
    end else if (cont_event) begin
      contention_q <= 1'b1;
      if (wb.clr_err) begin
        cont_cnt_q <= CNT_ONE;
      end else if (cont_cnt_q != CNT_MAX) begin
        cont_cnt_q <= cont_cnt_q + CNT_ONE;
      end
    end else if (wb.clr_err) begin
      contention_q <= 1'b0;
      cont_cnt_q   <= '0;
    end
  end

  assign wb.bus        = bus_q;
  assign wb.bus_valid  = bus_valid_q;
  assign wb.bus_src    = bus_src_q;
  assign wb.bus_hi     = bus_hi_q;
  assign wb.wide_busy  = in_wide;
  assign wb.wide_done  = (state == ST_HI);
  assign wb.contention = contention_q;
  assign wb.cont_cnt   = cont_cnt_q;
  assign dbg_state     = state;

endmodule
